// File: rtl/ahb_xbar_pkg.sv
// ahb_xbar_pkg: shared AHB-Lite encodings and crossbar FSM states
package ahb_xbar_pkg;
  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;
  localparam logic [1:0] HRESP_OKAY    = 2'b00;
  localparam logic [1:0] HRESP_ERROR   = 2'b01;
  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} xbar_state_e;
endpackage

// File: rtl/ahb_dflt_rsp.sv
// ahb_dflt_rsp: crossbar data-phase FSM and built-in default slave (two-cycle ERROR)
module ahb_dflt_rsp
  import ahb_xbar_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hready,
  input  logic        req_slv,
  input  logic        req_dflt,
  input  logic        abort,
  output xbar_state_e state,
  output logic        dflt_hready,
  output logic [1:0]  dflt_hresp
);
  xbar_state_e state_q, state_d;
  // a stalled data phase can only be in DATA; every ready cycle accepts the next transfer
  always_comb begin
    state_d = state_q == ERR1 ? ERR2 :
              !hready         ? (abort ? ERR1 : DATA) :
              req_dflt        ? ERR1 :
              req_slv         ? DATA : IDLE;
  end
  always_ff @(posedge clk) begin
    state_q <= rst ? IDLE : state_d;
  end
  assign state       = state_q;
  assign dflt_hready = state_q != ERR1;
  assign dflt_hresp  = (state_q == ERR1 || state_q == ERR2) ? HRESP_ERROR : HRESP_OKAY;
endmodule

// File: rtl/ahb_lite_xbar_n.sv
// ahb_lite_xbar_n: single-master AHB-Lite interconnect with base/mask decode, SMPU deny,
// default error slave and a hang watchdog that quarantines stalled slaves.
module ahb_lite_xbar_n
  import ahb_xbar_pkg::*;
#(
  parameter int                        NUM_SLV     = 4,
  parameter int                        ADDR_W      = 32,
  parameter int                        DATA_W      = 32,
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_BASE    = {NUM_SLV{32'h0}},
  parameter logic [NUM_SLV*ADDR_W-1:0] SLV_MASK    = {NUM_SLV{32'hF000_0000}},
  parameter int                        TIMEOUT_CYC = 256
)(
  input  logic                      pll_core_cpuclk,
  input  logic                      sys_rst,
  input  logic [ADDR_W-1:0]         m_haddr,
  input  logic [1:0]                m_htrans,
  input  logic                      m_hwrite,
  input  logic [2:0]                m_hsize,
  input  logic [2:0]                m_hburst,
  input  logic [3:0]                m_hprot,
  input  logic [DATA_W-1:0]         m_hwdata,
  output logic [DATA_W-1:0]         m_hrdata,
  output logic                      m_hready,
  output logic [1:0]                m_hresp,
  input  logic                      smpu_deny,
  input  logic                      clear_hung,
  output logic [NUM_SLV-1:0]        s_hsel,
  output logic [ADDR_W-1:0]         s_haddr,
  output logic [1:0]                s_htrans,
  output logic                      s_hwrite,
  output logic [2:0]                s_hsize,
  output logic [2:0]                s_hburst,
  output logic [3:0]                s_hprot,
  output logic [DATA_W-1:0]         s_hwdata,
  output logic                      s_hready_in,
  input  logic [NUM_SLV*DATA_W-1:0] s_hrdata,
  input  logic [NUM_SLV-1:0]        s_hreadyout,
  input  logic [NUM_SLV*2-1:0]      s_hresp,
  output logic [NUM_SLV-1:0]        hung_mask,
  output logic                      timeout_evt
);
  localparam int WCW = TIMEOUT_CYC < 2 ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam int IW  = NUM_SLV < 2 ? 1 : $clog2(NUM_SLV);
  xbar_state_e        state;
  logic               active, hit, req_slv, req_dflt, in_data, abort, dflt_hready;
  logic [1:0]         dflt_hresp;
  logic [IW-1:0]      win, sel;
  logic [NUM_SLV:0]   dsel_q, dsel_d;
  logic [WCW-1:0]     wcnt_q, wcnt_d;
  logic [NUM_SLV-1:0] hung_mask_q, hung_mask_d;
  logic               timeout_evt_q, timeout_evt_d;
  // descending scan so the lowest matching index is the one left in win
  always_comb begin
    hit = 1'b0;
    win = '0;
    for (int i = NUM_SLV - 1; i >= 0; i--)
      if ((m_haddr & SLV_MASK[i*ADDR_W +: ADDR_W]) == (SLV_BASE[i*ADDR_W +: ADDR_W] & SLV_MASK[i*ADDR_W +: ADDR_W])) begin
        hit = 1'b1;
        win = IW'(i);
      end
  end
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SLV; i++)
      if (dsel_q[i]) sel = IW'(i);
  end
  assign active   = !(m_htrans inside {HTRANS_IDLE, HTRANS_BUSY});
  assign req_slv  = active && hit && !smpu_deny && !hung_mask_q[win];
  assign req_dflt = active && !req_slv;
  assign s_hsel   = req_slv ? NUM_SLV'(1) << win : '0;
  assign in_data  = state == DATA;
  assign m_hready = in_data ? s_hreadyout[sel] : dflt_hready;
  assign m_hresp  = in_data ? s_hresp[sel*2 +: 2] : dflt_hresp;
  assign m_hrdata = in_data ? s_hrdata[sel*DATA_W +: DATA_W] : '0;
  assign abort    = TIMEOUT_CYC != 0 && in_data && !m_hready && wcnt_q == WCW'(TIMEOUT_CYC - 1);
  always_comb begin
    dsel_d        = m_hready ? {!req_slv, s_hsel} : dsel_q;
    wcnt_d        = in_data && !m_hready ? wcnt_q + 1'b1 : '0;
    timeout_evt_d = abort;
    hung_mask_d   = (clear_hung ? '0 : hung_mask_q) | (timeout_evt_q ? dsel_q[NUM_SLV-1:0] : '0);
  end
  always_ff @(posedge pll_core_cpuclk) begin
    if (sys_rst) begin
      dsel_q        <= {1'b1, {NUM_SLV{1'b0}}};
      wcnt_q        <= '0;
      timeout_evt_q <= 1'b0;
      hung_mask_q   <= '0;
    end else begin
      dsel_q        <= dsel_d;
      wcnt_q        <= wcnt_d;
      timeout_evt_q <= timeout_evt_d;
      hung_mask_q   <= hung_mask_d;
    end
  end
  ahb_dflt_rsp u_dflt (
    .clk        (pll_core_cpuclk),
    .rst        (sys_rst),
    .hready     (m_hready),
    .req_slv    (req_slv),
    .req_dflt   (req_dflt),
    .abort      (abort),
    .state      (state),
    .dflt_hready(dflt_hready),
    .dflt_hresp (dflt_hresp)
  );
  assign s_haddr     = m_haddr;
  assign s_htrans    = m_htrans;
  assign s_hwrite    = m_hwrite;
  assign s_hsize     = m_hsize;
  assign s_hburst    = m_hburst;
  assign s_hprot     = m_hprot;
  assign s_hwdata    = m_hwdata;
  assign s_hready_in = m_hready;
  assign hung_mask   = hung_mask_q;
  assign timeout_evt = timeout_evt_q;
endmodule
